// File: rtl/invaders_io.sv
// I/O port block for the Space Invaders i8080 system: IN port decode onto the shared
// data bus, OUT capture into the barrel shifter, sound latches and watchdog.
module invaders_io #(
   parameter int XLEN      = 8,
   parameter int WDT_WIDTH = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      io_addr,
   inout  wire [XLEN-1:0]  data,
   input  logic            st_inp,
   input  logic            st_out,
   input  logic            dbin,
   input  logic            write_n,
   input  logic [6:0]      btn,
   input  logic [7:0]      dip,
   output logic [XLEN-1:0] sound_a,
   output logic [XLEN-1:0] sound_b,
   output logic            wdt_expire
);

   logic [6:0]           btn_s1, btn_s2;
   logic                 coin_prev, coin_latch;
   logic                 rd_p1_q, write_n_q;
   logic [15:0]          shift_reg;
   logic [15:0]          shifted;
   logic [2:0]           offset;
   logic [WDT_WIDTH-1:0] wdt_cnt;
   logic                 rd_win, rd_p1, wr_stb;
   logic                 coin_rise, coin_clr, wdt_kick, wdt_max;
   logic [XLEN-1:0]      rd_byte;
   logic                 unused_dip;

   assign unused_dip = dip[3];

   // Bus protocol: the block drives data only while st_inp & dbin; an OUT write is
   // taken once, on the first cycle write_n is low (high-to-low edge seen via write_n_q).
   assign rd_win    = st_inp & dbin;
   assign rd_p1     = rd_win & (io_addr == 8'd1);
   assign wr_stb    = st_out & ~write_n & write_n_q;
   assign coin_rise = btn_s2[0] & ~coin_prev;
   assign coin_clr  = rd_p1_q & ~rd_p1;
   assign wdt_kick  = wr_stb & (io_addr == 8'd6);
   assign wdt_max   = &wdt_cnt;
   assign shifted   = shift_reg << offset;

   always_comb begin
      rd_byte = '0;
      case (io_addr)
         8'd0:    rd_byte = 8'h0E;
         8'd1:    rd_byte = {1'b0, btn_s2[5], btn_s2[4], btn_s2[3], 1'b1,
                             btn_s2[2], btn_s2[1], coin_latch};
         8'd2:    rd_byte = {dip[7:4], btn_s2[6], dip[2:0]};
         8'd3:    rd_byte = shifted[15:8];
         default: rd_byte = '0;
      endcase
   end

   assign data = rd_win ? rd_byte : {XLEN{1'bz}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_s1     <= '0;
         btn_s2     <= '0;
         coin_prev  <= 1'b0;
         coin_latch <= 1'b0;
         rd_p1_q    <= 1'b0;
         write_n_q  <= 1'b1;
         shift_reg  <= '0;
         offset     <= '0;
         sound_a    <= '0;
         sound_b    <= '0;
         wdt_cnt    <= '0;
         wdt_expire <= 1'b0;
      end else begin
         btn_s1    <= btn;
         btn_s2    <= btn_s1;
         coin_prev <= btn_s2[0];
         rd_p1_q   <= rd_p1;
         write_n_q <= write_n;

         // A new coin edge beats the read-acknowledge clear.
         if (coin_rise)
            coin_latch <= 1'b1;
         else if (coin_clr)
            coin_latch <= 1'b0;

         if (wr_stb) begin
            case (io_addr)
               8'd2:    offset    <= data[2:0];
               8'd3:    sound_a   <= data;
               8'd4:    shift_reg <= {data, shift_reg[15:8]};
               8'd5:    sound_b   <= data;
               default: ;
            endcase
         end

         wdt_expire <= 1'b0;
         if (wdt_kick) begin
            wdt_cnt <= '0;
         end else if (wdt_max) begin
            wdt_cnt    <= '0;
            wdt_expire <= 1'b1;
         end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_invaders_io.sv
// Directed bench for invaders_io: port reads, OUT capture, coin latch, bus release,
// watchdog period and reset override, with hand-computed expected bytes.
module tb_invaders_io;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] io_addr;
   wire  [7:0] data;
   logic       st_inp, st_out, dbin, write_n;
   logic [6:0] btn;
   logic [7:0] dip;
   logic [7:0] sound_a, sound_b;
   logic       wdt_expire;

   logic       drv_en;
   logic [7:0] drv_val;
   assign data = drv_en ? drv_val : 8'hzz;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         pulse_q[$];
   logic [7:0] exp_q[$];

   invaders_io #(.XLEN(8), .WDT_WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_addr    (io_addr),
      .data       (data),
      .st_inp     (st_inp),
      .st_out     (st_out),
      .dbin       (dbin),
      .write_n    (write_n),
      .btn        (btn),
      .dip        (dip),
      .sound_a    (sound_a),
      .sound_b    (sound_b),
      .wdt_expire (wdt_expire)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      if (wdt_expire) pulse_q.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic out_cycle(input logic [7:0] port, input logic [7:0] val, input int low_cycles);
      st_out  = 1'b1;
      io_addr = port;
      drv_val = val;
      drv_en  = 1'b1;
      write_n = 1'b1;
      tick();
      write_n = 1'b0;
      repeat (low_cycles) tick();
      write_n = 1'b1;
      st_out  = 1'b0;
      drv_en  = 1'b0;
      tick();
   endtask

   task automatic in_check(input string tag, input logic [7:0] port, input logic [7:0] exp);
      exp_q.push_back(exp);
      st_inp  = 1'b1;
      io_addr = port;
      dbin    = 1'b1;
      #1;
      check(tag, data, exp_q.pop_front());
      tick();
      dbin   = 1'b0;
      st_inp = 1'b0;
      tick();
   endtask

   // The bench drives a pattern; any concurrent drive from the block corrupts it.
   task automatic probe_z(input string tag, input logic [7:0] pat);
      drv_val = pat;
      drv_en  = 1'b1;
      #1;
      check(tag, data, pat);
      drv_en = 1'b0;
   endtask

   initial begin
      int   p;
      int   nxt;
      int   n0;
      logic found;

      rst_n   = 1'b0;
      io_addr = 8'd0;
      st_inp  = 1'b0;
      st_out  = 1'b0;
      dbin    = 1'b0;
      write_n = 1'b1;
      btn     = '0;
      dip     = 8'hA5;
      drv_en  = 1'b0;
      drv_val = '0;
      repeat (3) tick();

      check("rst_sound_a", sound_a, 8'h00);
      check("rst_sound_b", sound_b, 8'h00);
      check("rst_wdt", {7'd0, wdt_expire}, 8'h00);
      probe_z("rst_bus_z", 8'h30);
      rst_n = 1'b1;
      tick();

      in_check("rst_port1", 8'd1, 8'h08);
      in_check("rst_port3", 8'd3, 8'h00);
      in_check("port0", 8'd0, 8'h0E);
      in_check("port2_dip", 8'd2, 8'hA5);
      btn[6] = 1'b1;
      repeat (3) tick();
      in_check("port2_tilt", 8'd2, 8'hAD);
      btn[6] = 1'b0;
      repeat (3) tick();
      in_check("port9", 8'd9, 8'h00);

      // Bus must stay released outside the IN window.
      io_addr = 8'd0;
      probe_z("idle_z", 8'h30);
      st_out = 1'b1;
      probe_z("out_dbin_lo_z", 8'h30);
      dbin = 1'b1;
      probe_z("out_dbin_hi_z", 8'h30);
      dbin   = 1'b0;
      st_out = 1'b0;
      st_inp = 1'b1;
      probe_z("inp_dbin_lo_z", 8'h30);
      st_inp = 1'b0;
      tick();

      out_cycle(8'd4, 8'hAB, 1);
      out_cycle(8'd4, 8'hCD, 1);
      out_cycle(8'd2, 8'd3, 1);
      in_check("shift_off3", 8'd3, 8'h6D);
      out_cycle(8'd2, 8'd0, 1);
      in_check("shift_off0", 8'd3, 8'hCD);

      out_cycle(8'd4, 8'h12, 5);
      out_cycle(8'd2, 8'd7, 1);
      in_check("long_write", 8'd3, 8'h66);

      out_cycle(8'd5, 8'h5A, 1);
      check("sound_b", sound_b, 8'h5A);
      out_cycle(8'd7, 8'hFF, 1);
      check("port7_ign_a", sound_a, 8'h00);
      check("port7_ign_b", sound_b, 8'h5A);

      btn[0] = 1'b1;
      repeat (2) tick();
      btn[0] = 1'b0;
      repeat (4) tick();
      in_check("coin_set", 8'd1, 8'h09);
      in_check("coin_clr", 8'd1, 8'h08);
      btn[4] = 1'b1;
      repeat (3) tick();
      in_check("p1_left", 8'd1, 8'h28);
      btn[4] = 1'b0;
      tick();

      n0 = pulse_q.size();
      for (int i = 0; i < 40 && pulse_q.size() < n0 + 2; i++) tick();
      nxt = (pulse_q.size() >= n0 + 2) ? pulse_q[n0 + 1] - pulse_q[n0] : 0;
      check("wdt_period", 8'(nxt), 8'd16);

      found = 1'b0;
      p     = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (wdt_expire) begin
            found = 1'b1;
            p     = cyc;
         end
      end
      check("wdt_seen", {7'd0, found}, 8'h01);
      repeat (14) tick();
      st_out  = 1'b1;
      io_addr = 8'd6;
      drv_val = 8'h00;
      drv_en  = 1'b1;
      write_n = 1'b1;
      tick();
      write_n = 1'b0;
      tick();
      write_n = 1'b1;
      st_out  = 1'b0;
      drv_en  = 1'b0;
      check("wdt_suppressed", {7'd0, wdt_expire}, 8'h00);
      repeat (20) tick();
      nxt = 0;
      foreach (pulse_q[i]) if (nxt == 0 && pulse_q[i] > p) nxt = pulse_q[i];
      check("wdt_after_kick", 8'(nxt - p), 8'd32);

      out_cycle(8'd3, 8'h3C, 1);
      check("sound_a", sound_a, 8'h3C);
      st_out  = 1'b1;
      io_addr = 8'd3;
      drv_val = 8'h99;
      drv_en  = 1'b1;
      write_n = 1'b1;
      tick();
      write_n = 1'b0;
      rst_n   = 1'b0;
      tick();
      rst_n   = 1'b1;
      write_n = 1'b1;
      st_out  = 1'b0;
      drv_en  = 1'b0;
      check("rst_over_strobe", sound_a, 8'h00);
      repeat (3) tick();
      check("rst_no_late_upd", sound_a, 8'h00);
      check("rst_sound_b2", sound_b, 8'h00);
      in_check("rst_shift", 8'd3, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
